// File: rtl/checkpoint_ctrl_pkg.sv
// rtl/checkpoint_ctrl_pkg.sv - shared types for the rename map-table checkpoint controller
package checkpoint_ctrl_pkg;

    localparam int ARCH_REGS = 32;
    localparam int PREG_W    = 7;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        PENDING  = 2'd1,
        RESOLVED = 2'd2
    } ckpt_state_e;

    // Index [r] yields the physical register currently mapped to architectural register r.
    typedef logic [0:ARCH_REGS-1][PREG_W-1:0] map_t;

endpackage

// File: rtl/ckpt_ram.sv
// rtl/ckpt_ram.sv - checkpoint map storage, one write port and one combinational read port
module ckpt_ram
    import checkpoint_ctrl_pkg::*;
#(
    parameter int NUM_CKPT = 4,
    parameter int TAG_W    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [TAG_W-1:0] waddr,
    input  map_t             wdata,
    input  logic [TAG_W-1:0] raddr,
    output map_t             rdata
);

    map_t mem_q [NUM_CKPT];

    // Contents are never cleared; slot state in the controller decides validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/checkpoint_ctrl.sv
// rtl/checkpoint_ctrl.sv - circular-buffer allocator of map-table checkpoints with branch rollback
module checkpoint_ctrl
    import checkpoint_ctrl_pkg::*;
#(
    parameter int NUM_CKPT = 4,
    parameter int TAG_W    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  map_t             map_in,
    input  logic             br_valid,
    output logic             br_ready,
    output logic [TAG_W-1:0] br_tag,
    input  logic             resolve_valid,
    input  logic [TAG_W-1:0] resolve_tag,
    input  logic             mispredict,
    output logic             restore,
    output map_t             re_map,
    output logic [TAG_W:0]   ckpt_count
);

    localparam int CNT_W = TAG_W + 1;

    ckpt_state_e      slot_q [NUM_CKPT];
    ckpt_state_e      slot_d [NUM_CKPT];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             res_hit;
    logic             alloc;
    logic             retire;
    logic [TAG_W-1:0] mp_age;

    always_comb begin
        res_hit  = resolve_valid && (slot_q[resolve_tag] != FREE);
        restore  = res_hit && mispredict;
        br_ready = (count_q < CNT_W'(NUM_CKPT)) && !restore;
        alloc    = br_valid && br_ready;
        mp_age   = resolve_tag - head_q;
        // A rollback to the head itself empties the buffer, so nothing is left to retire.
        retire   = (slot_q[head_q] == RESOLVED) && !(restore && (mp_age == '0));
    end

    assign br_tag     = tail_q;
    assign ckpt_count = count_q;

    always_comb begin
        for (int i = 0; i < NUM_CKPT; i++) begin
            slot_d[i] = slot_q[i];
        end
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        if (alloc) begin
            slot_d[tail_q] = PENDING;
            tail_d         = tail_q + 1'b1;
        end
        if (res_hit && !mispredict && (slot_q[resolve_tag] == PENDING)) begin
            slot_d[resolve_tag] = RESOLVED;
        end
        if (retire) begin
            slot_d[head_q] = FREE;
            head_d         = head_q + 1'b1;
        end

        if (restore) begin
            // Free the mispredicted slot and everything allocated after it (age measured from head).
            for (int i = 0; i < NUM_CKPT; i++) begin
                if ((TAG_W'(i) - head_q) >= mp_age) begin
                    slot_d[i] = FREE;
                end
            end
            tail_d  = resolve_tag;
            count_d = {1'b0, mp_age} - CNT_W'(retire);
        end else begin
            count_d = count_q + CNT_W'(alloc) - CNT_W'(retire);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                slot_q[i] <= FREE;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                slot_q[i] <= slot_d[i];
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    ckpt_ram #(
        .NUM_CKPT (NUM_CKPT),
        .TAG_W    (TAG_W)
    ) u_ram (
        .clk   (clk),
        .we    (alloc),
        .waddr (tail_q),
        .wdata (map_in),
        .raddr (resolve_tag),
        .rdata (re_map)
    );

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// tb/tb_checkpoint_ctrl.sv - scoreboard bench for checkpoint_ctrl with directed vectors
module tb_checkpoint_ctrl;
    import checkpoint_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    map_t       map_in;
    logic       br_valid;
    logic       br_ready;
    logic [1:0] br_tag;
    logic       resolve_valid;
    logic [1:0] resolve_tag;
    logic       mispredict;
    logic       restore;
    map_t       re_map;
    logic [2:0] ckpt_count;

    typedef struct {
        int         step;
        logic       rdy;
        logic [1:0] tag;
        logic       rst;
        logic [6:0] rm1;
        logic [2:0] cnt;
    } exp_t;

    exp_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;

    always #5 clk = ~clk;

    checkpoint_ctrl #(.NUM_CKPT(4), .TAG_W(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .map_in        (map_in),
        .br_valid      (br_valid),
        .br_ready      (br_ready),
        .br_tag        (br_tag),
        .resolve_valid (resolve_valid),
        .resolve_tag   (resolve_tag),
        .mispredict    (mispredict),
        .restore       (restore),
        .re_map        (re_map),
        .ckpt_count    (ckpt_count)
    );

    // Monitor: compare the outputs of every checked cycle against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (br_ready !== e.rdy) begin
                failures++;
                $display("FAIL step %0d br_ready got=%0b exp=%0b", e.step, br_ready, e.rdy);
            end
            checks++;
            if (br_tag !== e.tag) begin
                failures++;
                $display("FAIL step %0d br_tag got=%0d exp=%0d", e.step, br_tag, e.tag);
            end
            checks++;
            if (restore !== e.rst) begin
                failures++;
                $display("FAIL step %0d restore got=%0b exp=%0b", e.step, restore, e.rst);
            end
            checks++;
            if (ckpt_count !== e.cnt) begin
                failures++;
                $display("FAIL step %0d ckpt_count got=%0d exp=%0d", e.step, ckpt_count, e.cnt);
            end
            if (e.rst) begin
                checks++;
                if (re_map[1] !== e.rm1) begin
                    failures++;
                    $display("FAIL step %0d re_map[1] got=%0d exp=%0d", e.step, re_map[1], e.rm1);
                end
            end
        end
    end

    task automatic cyc(input logic rs, input logic bv, input logic [6:0] m1,
                       input logic rv, input logic [1:0] rt, input logic mp,
                       input logic chk, input logic e_rdy, input logic [1:0] e_tag,
                       input logic e_rst, input logic [6:0] e_rm1, input logic [2:0] e_cnt);
        exp_t e;
        #1;
        reset         = rs;
        br_valid      = bv;
        map_in        = '0;
        map_in[0]     = 7'd1;
        map_in[1]     = m1;
        map_in[31]    = m1 + 7'd5;
        resolve_valid = rv;
        resolve_tag   = rt;
        mispredict    = mp;
        step_no++;
        if (chk) begin
            e.step = step_no;
            e.rdy  = e_rdy;
            e.tag  = e_tag;
            e.rst  = e_rst;
            e.rm1  = e_rm1;
            e.cnt  = e_cnt;
            exp_q.push_back(e);
        end
        @(posedge clk);
    endtask

    initial begin
        reset = 1'b0; br_valid = 1'b0; map_in = '0;
        resolve_valid = 1'b0; resolve_tag = '0; mispredict = 1'b0;
        repeat (2) @(posedge clk);

        //  rs bv  m1    rv  rt  mp  chk rdy tag rst rm1   cnt
        cyc(1, 0, 7'd0,  0, 0, 0,  1,  1,  0,  0, 7'd0,  0); // reset state
        cyc(1, 1, 7'd33, 0, 0, 0,  1,  1,  0,  0, 7'd0,  0);
        cyc(1, 1, 7'd34, 0, 0, 0,  1,  1,  1,  0, 7'd0,  1);
        cyc(1, 1, 7'd35, 0, 0, 0,  1,  1,  2,  0, 7'd0,  2);
        cyc(1, 1, 7'd36, 0, 0, 0,  1,  1,  3,  0, 7'd0,  3);
        cyc(1, 1, 7'd99, 0, 0, 0,  1,  0,  0,  0, 7'd0,  4); // full, no alloc
        cyc(1, 0, 7'd0,  1, 1, 0,  1,  0,  0,  0, 7'd0,  4); // resolve 1 ok
        cyc(1, 0, 7'd0,  1, 0, 0,  1,  0,  0,  0, 7'd0,  4); // resolve 0 ok
        cyc(1, 1, 7'd98, 0, 0, 0,  1,  0,  0,  0, 7'd0,  4); // head retires, no bypass
        cyc(1, 0, 7'd0,  0, 0, 0,  1,  1,  0,  0, 7'd0,  3); // head 1 retires
        cyc(1, 0, 7'd0,  0, 0, 0,  1,  1,  0,  0, 7'd0,  2);
        cyc(1, 1, 7'd37, 0, 0, 0,  1,  1,  0,  0, 7'd0,  2); // live 2,3,0
        cyc(1, 1, 7'd77, 1, 3, 1,  1,  0,  1,  1, 7'd36, 3); // mispredict 3, alloc blocked
        cyc(1, 0, 7'd0,  0, 0, 0,  1,  1,  3,  0, 7'd0,  1);
        cyc(1, 0, 7'd0,  1, 0, 1,  1,  1,  3,  0, 7'd0,  1); // free tag, ignored
        cyc(1, 0, 7'd0,  0, 0, 0,  1,  1,  3,  0, 7'd0,  1);
        cyc(1, 1, 7'd40, 0, 0, 0,  1,  1,  3,  0, 7'd0,  1);
        cyc(1, 1, 7'd41, 0, 0, 0,  1,  1,  0,  0, 7'd0,  2);
        cyc(1, 0, 7'd0,  1, 2, 0,  1,  1,  1,  0, 7'd0,  3); // resolve head 2 ok
        cyc(1, 0, 7'd0,  1, 0, 1,  1,  0,  1,  1, 7'd41, 3); // mispredict 0 + retire 2
        cyc(1, 0, 7'd0,  0, 0, 0,  1,  1,  0,  0, 7'd0,  1);
        cyc(1, 0, 7'd0,  1, 3, 1,  1,  0,  0,  1, 7'd40, 1); // mispredict head
        cyc(1, 0, 7'd0,  0, 0, 0,  1,  1,  3,  0, 7'd0,  0);
        cyc(1, 0, 7'd0,  1, 3, 1,  1,  1,  3,  0, 7'd0,  0); // empty, ignored
        cyc(1, 1, 7'd50, 0, 0, 0,  1,  1,  3,  0, 7'd0,  0);
        cyc(1, 1, 7'd51, 0, 0, 0,  1,  1,  0,  0, 7'd0,  1);
        cyc(1, 1, 7'd52, 0, 0, 0,  1,  1,  1,  0, 7'd0,  2);
        cyc(0, 1, 7'd53, 1, 3, 1,  0,  0,  0,  0, 7'd0,  0); // reset mid-operation
        cyc(1, 0, 7'd0,  0, 0, 0,  1,  1,  0,  0, 7'd0,  0);
        cyc(1, 0, 7'd0,  1, 0, 1,  1,  1,  0,  0, 7'd0,  0); // old tag 0 now free

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/checkpoint_ctrl.md
CHECKPOINT_CTRL -- requirements
Module: checkpoint_ctrl

Interface
REQ-001 Parameter NUM_CKPT, default 4: number of map-table checkpoint slots.
REQ-002 Parameter TAG_W, default 2: checkpoint tag width, log2(NUM_CKPT).
REQ-003 clk  in  1: single clock; all state updates on posedge.
REQ-004 reset  in  1: synchronous, active-low reset.
REQ-005 map_in  in  7 x [0:31]: current rename map-table contents.
REQ-006 br_valid  in  1: rename presents a branch this cycle.
REQ-007 br_ready  out  1: a checkpoint slot can be allocated this cycle.
REQ-008 br_tag  out  TAG_W: tag assigned to the branch; meaningful when br_valid && br_ready.
REQ-009 resolve_valid  in  1: a branch resolves this cycle.
REQ-010 resolve_tag  in  TAG_W: tag of the resolving branch.
REQ-011 mispredict  in  1: qualifies resolve_valid; 1 = mispredicted.
REQ-012 restore  out  1: map-table rollback strobe, drives the map table's mispredict input.
REQ-013 re_map  out  7 x [0:31]: checkpointed map to restore.
REQ-014 ckpt_count  out  TAG_W+1: number of live (allocated, not freed) slots.

Function
REQ-015 Slots form a circular buffer: head = oldest live slot, tail = next slot to allocate, both wrapping NUM_CKPT-1 -> 0.
REQ-016 Per-slot state: FREE, PENDING (allocated, unresolved) or RESOLVED (resolved correct, awaiting in-order free).
REQ-017 br_ready = (ckpt_count < NUM_CKPT) && !(resolve_valid && mispredict && slot[resolve_tag] != FREE), combinational.
REQ-018 br_tag = tail, combinational.
REQ-019 On allocation (br_valid && br_ready), map_in is copied into slot[tail] at the same edge, the slot becomes PENDING and tail increments.
REQ-020 A resolve whose resolve_tag addresses a FREE slot is ignored entirely, including restore.
REQ-021 Correct resolve (resolve_valid && !mispredict) moves the slot PENDING -> RESOLVED; the map is not touched.
REQ-022 Head retire: when slot[head] is RESOLVED, it becomes FREE and head increments; at most one retire per cycle.
REQ-023 restore = resolve_valid && mispredict && slot[resolve_tag] != FREE, combinational, zero-latency.
REQ-024 re_map = slot storage [resolve_tag], combinational; the map table samples it at the same edge as restore.
REQ-025 On mispredict of tag T: slot T and every slot younger than T (T through tail-1, wrapping) become FREE, and tail <= T.
REQ-026 Mispredict and head retire in the same cycle (T != head) both take effect: ckpt_count_next = ((T - head) mod NUM_CKPT) - retire.
REQ-027 Mispredict with T == head: all slots freed, ckpt_count becomes 0, and no retire occurs.
REQ-028 Full (ckpt_count == NUM_CKPT): br_ready = 0 even if the head retires in that cycle; there is no same-cycle bypass.
REQ-029 Empty (ckpt_count == 0): head == tail; resolves are ignored per REQ-020.
REQ-030 Without mispredict: ckpt_count_next = ckpt_count + alloc - retire.
REQ-031 Slot storage is not cleared on free; only slot state governs validity.

Reset
REQ-032 When reset is low at a posedge, head = 0, tail = 0, ckpt_count = 0 and every slot is FREE; storage contents are don't-care.
REQ-033 Outputs during and after reset: br_ready = 1, br_tag = 0, restore = 0, ckpt_count = 0; re_map is unconstrained while restore = 0.
REQ-034 Reset asserted mid-operation discards all checkpoints, including pending allocations and resolves in the same cycle.

Structure
REQ-035 A shared package holds ARCH_REGS = 32, PREG_W = 7, the ckpt_state_e enum (FREE, PENDING, RESOLVED) and the map_t array typedef.
REQ-036 Slot storage is the natural sub-module: ckpt_ram, with NUM_CKPT entries of map_t, one write port and one combinational read port; the control logic lives in checkpoint_ctrl.

Verification
REQ-037 Reset, then 4 allocations with map_in[1] = 33, 34, 35, 36 -> br_tag = 0, 1, 2, 3; br_ready = 0 after the 4th; ckpt_count = 4.
REQ-038 From that full state, resolve tag 1 correct, then tag 0 correct -> the head frees 0 then 1 on consecutive cycles; ckpt_count = 2; br_tag stays 0 (tail has wrapped).
REQ-039 Live tags 2, 3, 0 (oldest first), mispredict tag 3 -> restore = 1 and re_map[1] = 36 in the same cycle; tail = 3; ckpt_count = 1.
REQ-040 br_valid = 1 in the same cycle as a mispredict of a live tag -> br_ready = 0, no allocation, and tail ends at the mispredicted tag.
REQ-041 Resolve of a FREE tag with mispredict = 1 -> restore = 0 and no state change.
REQ-042 reset low while ckpt_count = 3 and resolve_valid = 1 -> next cycle: ckpt_count = 0, br_tag = 0, restore = 0.
